// File: rtl/aes_key_expand128_if.sv
// Key-schedule bus: start/key request from the consumer, round-key stream back to it.
interface aes_key_expand128_if;
   logic         key_start;
   logic [127:0] key_in;
   logic         key_ready;
   logic [127:0] round_key;
   logic         round_key_valid;
   logic [3:0]   round_num;
   logic         key_busy;
   logic         key_done;

   // Consumer side: requests a schedule and accepts round keys.
   modport master (
      output key_start,
      output key_in,
      output key_ready,
      input  round_key,
      input  round_key_valid,
      input  round_num,
      input  key_busy,
      input  key_done
   );

   // Generator side: the key-expansion block itself.
   modport slave (
      input  key_start,
      input  key_in,
      input  key_ready,
      output round_key,
      output round_key_valid,
      output round_num,
      output key_busy,
      output key_done
   );
endinterface

// File: rtl/aes_key_expand128.sv
// AES-128 key schedule: emits round keys 0..10 one per valid/ready handshake.
// All outputs come straight from registers; the expansion datapath only sees
// the registered round key and round number.
module aes_key_expand128 (
   input  logic              clk,
   input  logic              rst_n,
   aes_key_expand128_if.slave bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OUT  = 1'b1
   } state_t;

   // AES forward S-box.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant for the key being generated; unused indices give zero.
   function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon_lookup = 8'h01;
         4'd2:    rcon_lookup = 8'h02;
         4'd3:    rcon_lookup = 8'h04;
         4'd4:    rcon_lookup = 8'h08;
         4'd5:    rcon_lookup = 8'h10;
         4'd6:    rcon_lookup = 8'h20;
         4'd7:    rcon_lookup = 8'h40;
         4'd8:    rcon_lookup = 8'h80;
         4'd9:    rcon_lookup = 8'h1b;
         4'd10:   rcon_lookup = 8'h36;
         default: rcon_lookup = 8'h00;
      endcase
   endfunction

   state_t       r_state;
   state_t       w_state_next;
   logic [127:0] r_round_key;
   logic [127:0] w_round_key_next;
   logic [3:0]   r_round_num;
   logic [3:0]   w_round_num_next;
   logic         r_valid;
   logic         w_valid_next;
   logic         r_done;
   logic         w_done_next;

   logic [31:0]  w_w0;
   logic [31:0]  w_w1;
   logic [31:0]  w_w2;
   logic [31:0]  w_w3;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [31:0]  w_t;
   logic [31:0]  w_n0;
   logic [31:0]  w_n1;
   logic [31:0]  w_n2;
   logic [31:0]  w_n3;
   logic [3:0]   w_rcon_idx;
   logic [7:0]   w_rcon;
   logic [127:0] w_expanded;
   logic         w_handshake;

   // Split the registered key into words, w0 being the most significant.
   assign w_w0 = r_round_key[127:96];
   assign w_w1 = r_round_key[95:64];
   assign w_w2 = r_round_key[63:32];
   assign w_w3 = r_round_key[31:0];

   // RotWord: {a,b,c,d} -> {b,c,d,a}.
   assign w_rot = {w_w3[23:0], w_w3[31:24]};

   // SubWord: one S-box lookup per byte lane.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_subword
         assign w_sub[gi*8 +: 8] = SBOX[w_rot[gi*8 +: 8]];
      end
   endgenerate

   // Rcon index is the number of the key being produced; at round 10 it
   // rolls to 11 (zero) but the expanded value is never loaded then.
   assign w_rcon_idx = r_round_num + 4'd1;
   assign w_rcon     = rcon_lookup(w_rcon_idx);
   assign w_t        = w_sub ^ {w_rcon, 24'h000000};

   // Chained word XORs producing the next round key.
   assign w_n0       = w_w0 ^ w_t;
   assign w_n1       = w_w1 ^ w_n0;
   assign w_n2       = w_w2 ^ w_n1;
   assign w_n3       = w_w3 ^ w_n2;
   assign w_expanded = {w_n0, w_n1, w_n2, w_n3};

   assign w_handshake = r_valid & bus.key_ready;

   // Next-state and next-output decode; everything holds unless changed below.
   always_comb begin
      w_state_next     = r_state;
      w_round_key_next = r_round_key;
      w_round_num_next = r_round_num;
      w_valid_next     = r_valid;
      w_done_next      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.key_start) begin
               w_state_next     = ST_OUT;
               w_round_key_next = bus.key_in;
               w_round_num_next = 4'd0;
               w_valid_next     = 1'b1;
            end
         end
         ST_OUT: begin
            // key_start is deliberately not looked at here.
            if (w_handshake) begin
               if (r_round_num == 4'd10) begin
                  w_state_next = ST_IDLE;
                  w_valid_next = 1'b0;
                  w_done_next  = 1'b1;
               end else begin
                  w_round_key_next = w_expanded;
                  w_round_num_next = r_round_num + 4'd1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_valid_next = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Output/data registers; reset clears them immediately, aborting any sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_round_key <= 128'h0;
         r_round_num <= 4'd0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_round_key <= w_round_key_next;
         r_round_num <= w_round_num_next;
         r_valid     <= w_valid_next;
         r_done      <= w_done_next;
      end
   end

   assign bus.round_key       = r_round_key;
   assign bus.round_num       = r_round_num;
   assign bus.round_key_valid = r_valid;
   assign bus.key_done        = r_done;
   assign bus.key_busy        = (r_state == ST_OUT);

endmodule

// File: doc/aes_key_expand128.md
# aes_key_expand128

Sequential AES-128 key-schedule generator for the encryption round stage. It takes a 128-bit cipher key and emits the 11 round keys (round 0 through round 10) one per handshake, in order. The round stage's key input and the final-round stage consume these keys. A valid/ready handshake paces the output, so the consumer can stall key delivery when it needs to.

## Interface
- No parameters. Key size is fixed at 128 bits, with 10 rounds.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_start` input 1: start request. Accepted only in IDLE.
- `key_in` input 128: cipher key. `w0 = key_in[127:96]`, `w3 = key_in[31:0]`. Sampled on the accepted start.
- `key_ready` input 1: consumer accepts `round_key` this cycle.
- `round_key` output 128: current round key, same word order as `key_in`.
- `round_key_valid` output 1: `round_key`/`round_num` are valid.
- `round_num` output 4: index 0..10 of the current `round_key`.
- `key_busy` output 1: high in every state except IDLE.
- `key_done` output 1: one-cycle pulse after round key 10 is accepted.

## Operation
- States:
  - IDLE: waiting for a start.
  - OUT: presenting a key and waiting for the handshake.
- IDLE -> OUT when `key_start=1`:
  - `round_key <= key_in`, `round_num <= 0`, `round_key_valid <= 1`.
- OUT, handshake (`round_key_valid & key_ready`) with `round_num < 10`:
  - `round_key <= next_key(round_key, round_num+1)`.
  - `round_num` increments.
  - Stay in OUT.
- OUT, handshake with `round_num == 10`:
  - Go to IDLE, `round_key_valid <= 0`, `key_done <= 1` for one cycle.
  - `round_key` and `round_num` hold their last values.
- OUT, no handshake: all outputs hold.
- `key_start` in OUT is ignored. It does not restart and does not corrupt the sequence.
- `next_key` (FIPS-197) is combinational from the current `round_key` and a 4-bit rcon index `i`:
  - `t = SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}`, where `RotWord({a,b,c,d}) = {b,c,d,a}`.
  - `w0' = w0^t`, `w1' = w1^w0'`, `w2' = w2^w1'`, `w3' = w3^w2'`.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Index 0 and 11..15 map to 00; they are never used.
  - SubWord applies the AES forward S-box to each of the 4 bytes. Use 4 combinational lookups, local to this block.
- All XOR arithmetic is 32-bit, with no carries.

## Timing
- Reset values, applied asynchronously the moment `rst_n` falls:
  - state=IDLE, `round_key`=0, `round_num`=0.
  - `round_key_valid`=0, `key_busy`=0, `key_done`=0.
- Reset asserted mid-sequence aborts immediately. No `key_done` is produced. After release the block is in IDLE.
- Start latency: `key_start` sampled high at edge N gives `round_key_valid=1` with round 0 after edge N, with `key_busy=1`.
- Throughput: 1 key per cycle when `key_ready` is held high. 11 keys occupy 11 consecutive valid cycles.
- Sequence timing with `key_ready` held high: `key_done` is high in the cycle after the round-10 handshake, and `key_busy` is 0 in that same cycle.
- Earliest restart: `key_start` is accepted in the cycle `key_done` is high, because the block is already in IDLE. The next sequence then starts back-to-back.
- `key_ready` while `round_key_valid=0` has no effect.
- Output hold: `round_key` and `round_num` are stable from valid assertion until the handshake edge, for any number of stall cycles.
- Only the registered state feeds the critical path: S-box, then rcon XOR, then a 4-XOR chain, then the register. There are no combinational input-to-output paths.

## Test plan
- FIPS-197 vector, `key_ready`=1: `key_in`=2b7e151628aed2a6abf7158809cf4f3c.
  - Required sequence: round0 = key_in; round1 = a0fafe1788542cb123a339392a6c7605; round2 = f2c295f27a96b9435935807a7359f67f; round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `key_done` pulses once, 12 cycles after start.
- Backpressure: same key, `key_ready` toggled pseudo-randomly.
  - Key values match the first scenario.
  - `round_key` and `round_num` never change while `valid & !ready`.
  - Exactly 11 handshakes occur.
- Start while busy: pulse `key_start` with key 000102030405060708090a0b0c0d0e0f at round 4 of the FIPS sequence.
  - The sequence continues unaffected; round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Async reset mid-operation: deassert `rst_n` between clock edges at round 6.
  - Outputs go to 0 immediately, with no `key_done`.
  - After release, a new start with key 000102030405060708090a0b0c0d0e0f gives round10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: `key_start` held high continuously with `key_ready`=1.
  - A second sequence begins in the `key_done` cycle.
  - The round0 valid cycle follows immediately, with no idle bubble beyond the `key_done` cycle.
- Zero key 00..00: round1 = 62636363626363636263636362636363; round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
